display_sequencer: RTL and testbench

//  Responder end of the controller's display phase: buffers SA_2x2 results, then on state_display

---
 rtl/display_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_display_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_sequencer.sv
// display_sequencer: buffers a run of systolic-array results, then steps through them
// one dwell period at a time while the controller holds state_display, reporting the
// shown index on current_display (NUM_RESULTS marks the end of the run).
// Optional feature macro: DISPLAY_SEG_EN adds a registered active-low 7-segment
// decode of display_data[3:0] on port seg_n (gfedcba order, blank when not valid).
module display_sequencer #(
  parameter int DATA_W      = 16,
  parameter int NUM_RESULTS = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              state_display,
  input  logic              result_valid,
  input  logic [DATA_W-1:0] result_in,
  output logic [DATA_W-1:0] display_data,
  output logic              display_valid,
  output logic [2:0]        current_display,
  output logic              overflow
`ifdef DISPLAY_SEG_EN
  ,
  output logic [6:0]        seg_n
`endif
);

  localparam int PTR_W = $clog2(NUM_RESULTS + 1);
  localparam int DW_W  = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW_W-1:0]  DWELL_RELOAD = DW_W'(HOLD_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_FULL     = PTR_W'(NUM_RESULTS);
  localparam logic [2:0]       LAST_IDX     = 3'(NUM_RESULTS - 1);
  localparam logic [2:0]       TERMINAL_IDX = 3'(NUM_RESULTS);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] res_buf_q [NUM_RESULTS];
  logic [DATA_W-1:0] res_buf_d [NUM_RESULTS];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [DATA_W-1:0] display_data_q, display_data_d;
  logic              display_valid_q, display_valid_d;
  logic [2:0]        current_display_q, current_display_d;
  logic              overflow_q, overflow_d;
  logic [2:0]        next_idx;
  logic [DATA_W-1:0] rd_next;

`ifdef DISPLAY_SEG_EN
  logic [6:0] seg_n_q, seg_n_d;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] lit;
    case (v)
      4'h0: lit = 7'h3F;
      4'h1: lit = 7'h06;
      4'h2: lit = 7'h5B;
      4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66;
      4'h5: lit = 7'h6D;
      4'h6: lit = 7'h7D;
      4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F;
      4'h9: lit = 7'h6F;
      4'hA: lit = 7'h77;
      4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39;
      4'hD: lit = 7'h5E;
      4'hE: lit = 7'h79;
      default: lit = 7'h71;
    endcase
    return ~lit;
  endfunction
`endif

  // Next-state logic: buffer writes in idle, dwell stepping while showing, run teardown.
  always_comb begin
    state_d           = state_q;
    res_buf_d         = res_buf_q;
    wr_ptr_d          = wr_ptr_q;
    dwell_d           = dwell_q;
    display_data_d    = display_data_q;
    display_valid_d   = display_valid_q;
    current_display_d = current_display_q;
    overflow_d        = overflow_q;
    next_idx          = current_display_q + 3'd1;
    rd_next           = '0;
    for (int i = 0; i < NUM_RESULTS; i++) begin
      if (3'(i) == next_idx) rd_next = res_buf_q[i];
    end

    case (state_q)
      S_IDLE: begin
        current_display_d = '0;
        display_valid_d   = 1'b0;
        display_data_d    = '0;
        if (result_valid) begin
          if (wr_ptr_q < PTR_FULL) begin
            for (int i = 0; i < NUM_RESULTS; i++) begin
              if (PTR_W'(i) == wr_ptr_q) res_buf_d[i] = result_in;
            end
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        // A write landing in the same cycle as the start is already visible in slot 0.
        if (state_display) begin
          state_d         = S_SHOW;
          display_valid_d = 1'b1;
          display_data_d  = res_buf_d[0];
          dwell_d         = DWELL_RELOAD;
        end
      end

      S_SHOW: begin
        if (!state_display) begin
          state_d           = S_IDLE;
          current_display_d = '0;
          display_valid_d   = 1'b0;
          display_data_d    = '0;
          wr_ptr_d          = '0;
          for (int i = 0; i < NUM_RESULTS; i++) res_buf_d[i] = '0;
        end else if (dwell_q != '0) begin
          dwell_d = dwell_q - DW_W'(1);
        end else if (current_display_q < LAST_IDX) begin
          current_display_d = next_idx;
          display_data_d    = rd_next;
          dwell_d           = DWELL_RELOAD;
        end else begin
          state_d           = S_DONE;
          current_display_d = TERMINAL_IDX;
          display_valid_d   = 1'b0;
          display_data_d    = '0;
        end
      end

      S_DONE: begin
        if (!state_display) begin
          state_d           = S_IDLE;
          current_display_d = '0;
          display_valid_d   = 1'b0;
          display_data_d    = '0;
          wr_ptr_d          = '0;
          for (int i = 0; i < NUM_RESULTS; i++) res_buf_d[i] = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

`ifdef DISPLAY_SEG_EN
  // Decode tracks the value display_data is about to take, blank whenever nothing is shown.
  always_comb begin
    seg_n_d = 7'h7F;
    if (display_valid_d) seg_n_d = hex_to_seg(display_data_d[3:0]);
  end
`endif

  // State and output registers; reset clears everything including the sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_IDLE;
      for (int i = 0; i < NUM_RESULTS; i++) res_buf_q[i] <= '0;
      wr_ptr_q          <= '0;
      dwell_q           <= '0;
      display_data_q    <= '0;
      display_valid_q   <= 1'b0;
      current_display_q <= '0;
      overflow_q        <= 1'b0;
`ifdef DISPLAY_SEG_EN
      seg_n_q           <= 7'h7F;
`endif
    end else begin
      state_q           <= state_d;
      res_buf_q         <= res_buf_d;
      wr_ptr_q          <= wr_ptr_d;
      dwell_q           <= dwell_d;
      display_data_q    <= display_data_d;
      display_valid_q   <= display_valid_d;
      current_display_q <= current_display_d;
      overflow_q        <= overflow_d;
`ifdef DISPLAY_SEG_EN
      seg_n_q           <= seg_n_d;
`endif
    end
  end

  assign display_data    = display_data_q;
  assign display_valid   = display_valid_q;
  assign current_display = current_display_q;
  assign overflow        = overflow_q;
`ifdef DISPLAY_SEG_EN
  assign seg_n           = seg_n_q;
`endif

endmodule

// File: tb/tb_display_sequencer.sv
// Scoreboard bench for display_sequencer: the stimulus side predicts every shown
// (index, value) pair from a plain array model and queues it; a monitor pops one
// entry per cycle that display_valid is high and compares.
module tb_display_sequencer;

  localparam int DATA_W = 16;
  localparam int NR     = 4;
  localparam int HOLD   = 4;
  localparam int SHOW_CYCLES = NR * HOLD;

  typedef struct {
    logic [2:0]        idx;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              state_display = 1'b0;
  logic              result_valid = 1'b0;
  logic [DATA_W-1:0] result_in = '0;
  logic [DATA_W-1:0] display_data;
  logic              display_valid;
  logic [2:0]        current_display;
  logic              overflow;
`ifdef DISPLAY_SEG_EN
  logic [6:0]        seg_n;
  logic [6:0]        seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`endif

  exp_t              exp_q[$];
  logic [DATA_W-1:0] model_buf [NR];
  int                model_ptr = 0;
  logic              model_ovf = 1'b0;
  int                vectors = 0;
  int                miscompares = 0;
  logic              monitor_on = 1'b0;

  display_sequencer #(.DATA_W(DATA_W), .NUM_RESULTS(NR), .HOLD_CYCLES(HOLD)) dut (
    .clk            (clk),
    .reset          (reset),
    .state_display  (state_display),
    .result_valid   (result_valid),
    .result_in      (result_in),
    .display_data   (display_data),
    .display_valid  (display_valid),
    .current_display(current_display),
    .overflow       (overflow)
`ifdef DISPLAY_SEG_EN
    ,
    .seg_n          (seg_n)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive the inputs for the cycle following the next rising edge.
  task automatic applyStimulus(input logic rv, input logic [DATA_W-1:0] rd, input logic sd);
    @(posedge clk);
    #1;
    result_valid  = rv;
    result_in     = rd;
    state_display = sd;
  endtask

  task automatic modelWrite(input logic [DATA_W-1:0] v);
    if (model_ptr < NR) begin
      model_buf[model_ptr] = v;
      model_ptr++;
    end else begin
      model_ovf = 1'b1;
    end
  endtask

  task automatic modelClear(input logic clr_ovf);
    for (int i = 0; i < NR; i++) model_buf[i] = '0;
    model_ptr = 0;
    if (clr_ovf) model_ovf = 1'b0;
  endtask

  task automatic writeResult(input logic [DATA_W-1:0] v);
    applyStimulus(1'b1, v, 1'b0);
    modelWrite(v);
  endtask

  task automatic pushExpected(input int visible);
    exp_t e;
    for (int k = 0; k < visible && k < SHOW_CYCLES; k++) begin
      e.idx  = 3'(k / HOLD);
      e.data = model_buf[k / HOLD];
      exp_q.push_back(e);
    end
  endtask

  // Hold state_display for h sampled edges, with stray writes during the run.
  task automatic runDisplay(input int h, input logic start_wr, input logic [DATA_W-1:0] start_val);
    applyStimulus(start_wr, start_val, 1'b1);
    if (start_wr) modelWrite(start_val);
    pushExpected(h);
    for (int k = 1; k < h; k++) applyStimulus(1'($urandom_range(0, 1)), DATA_W'($urandom), 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    if (h > SHOW_CYCLES) begin
      checkOutput("terminal_index", 32'(current_display), NR);
      checkOutput("terminal_valid", 32'(display_valid), 0);
      checkOutput("terminal_data", 32'(display_data), 0);
    end
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("idle_index", 32'(current_display), 0);
    checkOutput("idle_valid", 32'(display_valid), 0);
    checkOutput("overflow_after_run", 32'(overflow), 32'(model_ovf));
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
    modelClear(1'b0);
  endtask

  task automatic runWithReset(input int h);
    applyStimulus(1'b0, '0, 1'b1);
    pushExpected(h);
    for (int k = 1; k < h; k++) applyStimulus(1'b0, '0, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    state_display = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    modelClear(1'b1);
    checkOutput("reset_index", 32'(current_display), 0);
    checkOutput("reset_valid", 32'(display_valid), 0);
    checkOutput("reset_data", 32'(display_data), 0);
    checkOutput("reset_overflow", 32'(overflow), 0);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: every live display cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (monitor_on) begin
      if (display_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_valid", 32'(display_valid), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("shown_index", 32'(current_display), 32'(e.idx));
          checkOutput("shown_data", 32'(display_data), 32'(e.data));
`ifdef DISPLAY_SEG_EN
          checkOutput("seg_live", 32'(seg_n), 32'(seg_tbl[e.data[3:0]]));
`endif
        end
      end
`ifdef DISPLAY_SEG_EN
      else checkOutput("seg_blank", 32'(seg_n), 32'h7F);
`endif
    end
  end

  initial begin
    int nw;
    modelClear(1'b1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_index", 32'(current_display), 0);
    checkOutput("reset_valid", 32'(display_valid), 0);
    checkOutput("reset_data", 32'(display_data), 0);
    checkOutput("reset_overflow", 32'(overflow), 0);
    monitor_on = 1'b1;

    $display("[TB] full run with four results");
    writeResult(16'h0011); writeResult(16'h0022); writeResult(16'h0033); writeResult(16'h0044);
    runDisplay(SHOW_CYCLES + 1, 1'b0, '0);

    $display("[TB] overflow on fifth write, sticky until reset");
    for (int i = 0; i < 5; i++) writeResult(DATA_W'($urandom));
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("overflow_set", 32'(overflow), 1);
    runDisplay(SHOW_CYCLES + 3, 1'b0, '0);
    runWithReset(3);

    $display("[TB] partial buffer shows zeros");
    writeResult(16'hAAAA); writeResult(16'hBBBB);
    runDisplay(SHOW_CYCLES + 1, 1'b0, '0);

    $display("[TB] abort at index 2, then empty run");
    for (int i = 0; i < NR; i++) writeResult(DATA_W'($urandom));
    runDisplay(2 * HOLD + 1, 1'b0, '0);
    runDisplay(SHOW_CYCLES + 2, 1'b0, '0);

    $display("[TB] reset mid-run, writes accepted afterwards");
    for (int i = 0; i < 3; i++) writeResult(DATA_W'($urandom));
    runWithReset(6);
    writeResult(16'h1234); writeResult(16'h0003);
    runDisplay(SHOW_CYCLES + 1, 1'b0, '0);

    $display("[TB] write in the start cycle");
    writeResult(16'h5A5A);
    runDisplay(SHOW_CYCLES + 1, 1'b1, 16'hC3C3);

    $display("[TB] randomized runs");
    for (int r = 0; r < 10; r++) begin
      nw = $urandom_range(0, NR + 2);
      for (int i = 0; i < nw; i++) writeResult(DATA_W'($urandom));
      runDisplay($urandom_range(1, SHOW_CYCLES + 3), 1'($urandom_range(0, 1)), DATA_W'($urandom));
    end

    monitor_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
